regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port among NUM_REQ writeback sources (ALU, load unit,
//  multiply unit). Round-robin arbitration, one accepted write per cycle, valid/ready per source.
//  Registered write-port outputs drive the register file's write side.
//  Holds the write stable while the register file signals stall.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  ADDR_W   6   register address width (64 registers)
//  DATA_W   72  register data width
// PORTS
//  clk        in   1               rising-edge clock, sole clock
//  reset      in   1               synchronous, active-low (0 = reset, sampled on clk rise)
//  req_valid  in   NUM_REQ         per-source write request
//  req_addr   in   NUM_REQ*ADDR_W  source i address at [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W  source i data at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ         one-hot or zero; source i accepted when valid[i]&ready[i]
//  rf_stall   in   1               register file cannot take a write this cycle
//  wr_en      out  1               write strobe to register file
//  wr_addr    out  ADDR_W          write address
//  wr_data    out  DATA_W          write data
//  wr_src     out  $clog2(NUM_REQ) index of source owning current write
// BEHAVIOUR
//  - Reset (reset==0 at clk rise): wr_en=0, wr_addr=0, wr_data=0, wr_src=0,
//    rr_ptr=0, state=IDLE. req_ready is 0 whenever reset==0.
//  - req_ready is combinational from req_valid, rr_ptr, state and rf_stall.
//    At most one bit is set. A bit is set only if that source's req_valid is 1.
//  - Grant: the first valid source scanning from rr_ptr upward, modulo NUM_REQ.
//    Grant is allowed when state==IDLE, or when state==WRITE and rf_stall==0.
//  - Acceptance: data is captured into wr_* at the same clk edge. wr_en=1 the next cycle (latency 1).
//    rr_ptr <= granted index + 1, wrapping NUM_REQ-1 -> 0. rr_ptr is unchanged when nothing is granted.
//  - FSM:
//    - IDLE: on accept go to WRITE; else stay, wr_en=0.
//    - WRITE: wr_en=1.
//      - rf_stall=1: go to HOLD; wr_* frozen; no grants.
//      - rf_stall=0: the write completes. On a new accept in the same cycle, stay WRITE with new
//        wr_* (back-to-back, one write per cycle). Otherwise go to IDLE.
//    - HOLD: wr_en=1, wr_* frozen, no grants while rf_stall=1. When rf_stall=0 the write
//      completes and the next state follows the WRITE rules, so a grant is allowed that cycle.
//  - wr_addr/wr_data/wr_src change only on acceptance. After a write completes they retain
//    their last values while wr_en=0.
//  - Same-address requests from two sources in one cycle: serialised in round-robin order.
//    The later grant's write lands last. No merging.
//  - A source dropping req_valid before it is granted is legal. A source must hold
//    addr/data stable while valid && !ready.
//  - reset==0 mid-write or mid-HOLD: the write is abandoned. wr_en=0 the next cycle and the
//    in-flight write is not replayed.
//  - Starvation bound: a continuously valid source is granted within NUM_REQ grants.
// STRUCTURE
//  - Shared package regfile_pkg:
//    - REG_ADDR_W=6, REG_DATA_W=72
//    - arb_state_t {IDLE, WRITE, HOLD}
//    - source-ID constants SRC_ALU=0, SRC_LOAD=1, SRC_MUL=2
//  - Sub-module rr_arbiter: req vector + ptr -> one-hot grant. Purely combinational,
//    parameterised by NUM_REQ. Pointer register, FSM and output registers stay in the top.
// TESTING
//  1. reset=0 for 2 cycles with req_valid=3'b111
//     -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0 throughout.
//  2. reset=1; only src1 valid, addr=6'h05, data=72'hAB
//     -> ready[1]=1 that cycle; next cycle wr_en=1, wr_addr=05, wr_data=AB, wr_src=1;
//        the cycle after, wr_en=0.
//  3. All 3 valid continuously, rr_ptr=0, rf_stall=0
//     -> grants 0,1,2,0,... one per cycle; wr_en held 1 back-to-back.
//  4. src0 accepted, then rf_stall=1 for 3 cycles with src2 valid
//     -> wr_en=1 and wr_* frozen 4 cycles, ready=0 during stall;
//        src2 is granted in the cycle rf_stall drops.
//  5. src0 and src1 both write addr 6'h0A (data 1 and 2), rr_ptr=0
//     -> write of data 1, then data 2 on consecutive cycles; last wr_data to 0A = 2.
//  6. reset=0 during HOLD -> wr_en=0 the next cycle, rr_ptr=0, state IDLE.
//     After release, a pending src2 request is granted normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: widths, arbiter
// FSM states and writeback source identifiers.
package regfile_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 72;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_MUL  = 2;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning upward from ptr, wrapping at NUM_REQ. The grant is one-hot or zero.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int PTR_W = $clog2(NUM_REQ);

    int               cand_s;
    logic [PTR_W-1:0] cand_idx_s;
    logic             found_s;

    // Rotating priority scan; the first hit from ptr wins, later hits are ignored.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s     = (int'(ptr) + off) % NUM_REQ;
            cand_idx_s = cand_s[PTR_W-1:0];
            if (!found_s && req[cand_idx_s]) begin
                grant[cand_idx_s] = 1'b1;
                grant_idx         = cand_idx_s;
                found_s           = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback sources.
// Round-robin grant, one accepted write per cycle, registered write-port
// outputs that stay frozen while the register file stalls.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        rf_stall,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  wr_src
);

    localparam int SRC_W = $clog2(NUM_REQ);

    arb_state_t         state_r;
    arb_state_t         state_next_s;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   rr_ptr_next_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic               grant_en_s;
    logic               accept_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [DATA_W-1:0]  wr_data_r;
    logic [SRC_W-1:0]   wr_src_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Grants open when idle, or when the current write completes this cycle.
    always_comb begin
        grant_en_s = 1'b0;
        if (!reset) begin
            grant_en_s = 1'b0;
        end else if (state_r == IDLE) begin
            grant_en_s = 1'b1;
        end else if (!rf_stall) begin
            grant_en_s = 1'b1;
        end else begin
            grant_en_s = 1'b0;
        end
    end

    assign req_ready = grant_en_s ? grant_s : '0;
    assign accept_s  = grant_en_s & (|grant_s);

    // One-hot AND-OR mux of the granted source's address and data.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s = sel_addr_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
            sel_data_s = sel_data_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        rr_ptr_next_s = '0;
        if (grant_idx_s == SRC_W'(NUM_REQ - 1)) begin
            rr_ptr_next_s = '0;
        end else begin
            rr_ptr_next_s = grant_idx_s + SRC_W'(1);
        end
    end

    // Next-state logic: a stall parks the pending write in HOLD, otherwise it
    // completes and a same-cycle accept chains straight into the next write.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE, HOLD: begin
                if (rf_stall) begin
                    state_next_s = HOLD;
                end else if (accept_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, pointer and write-port registers; reset abandons any in-flight write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            wr_src_r  <= '0;
        end else begin
            state_r <= state_next_s;
            wr_en_r <= (state_next_s != IDLE);
            if (accept_s) begin
                rr_ptr_r  <= rr_ptr_next_s;
                wr_addr_r <= sel_addr_s;
                wr_data_r <= sel_data_s;
                wr_src_r  <= grant_idx_s;
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign wr_src  = wr_src_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = REG_ADDR_W;
    localparam int DW = REG_DATA_W;
    localparam int SW = $clog2(N);

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rf_stall;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_src;

    int checks = 0;
    int errors = 0;

    // Current stimulus per source.
    logic [N-1:0]  cv;
    logic [AW-1:0] ca [N];
    logic [DW-1:0] cd [N];

    // Reference model: one pending write slot plus a rotating pointer.
    bit            m_busy;
    int            m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;
    int            last_grant;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_stall  (rf_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_valid(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus, check ready mid-cycle, then check outputs after the edge.
    task automatic run_cycle(input logic rst_v, input logic stall_v);
        int           g;
        logic [N-1:0] exp_ready;
        reset     = rst_v;
        rf_stall  = stall_v;
        req_valid = cv;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = ca[i];
            req_data[i*DW +: DW] = cd[i];
        end
        #2;
        g = (rst_v && !(m_busy && stall_v)) ? first_valid(cv, m_ptr) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 128'(req_ready), 128'(exp_ready));
        @(posedge clk);
        if (!rst_v) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_addr = '0;
            m_data = '0;
            m_src  = 0;
        end else if (g >= 0) begin
            m_busy = 1'b1;
            m_addr = ca[g];
            m_data = cd[g];
            m_src  = g;
            m_ptr  = (g + 1) % N;
        end else if (!stall_v) begin
            m_busy = 1'b0;
        end
        last_grant = g;
        #1;
        check("wr_en",   128'(wr_en),   128'(m_busy));
        check("wr_addr", 128'(wr_addr), 128'(m_addr));
        check("wr_data", 128'(wr_data), 128'(m_data));
        check("wr_src",  128'(wr_src),  128'(m_src));
    endtask

    task automatic set_fixed();
        for (int i = 0; i < N; i++) begin
            ca[i] = AW'(8'h10 + i);
            cd[i] = DW'(16'h0100 + i);
        end
    endtask

    initial begin
        logic [95:0] rnd;
        m_busy = 1'b0; m_ptr = 0; m_addr = '0; m_data = '0; m_src = 0; last_grant = -1;
        reset = 1'b0; rf_stall = 1'b0;
        cv = '0; set_fixed();
        req_valid = '0; req_addr = '0; req_data = '0;
        @(posedge clk); #1;

        // Reset held with every source requesting.
        cv = 3'b111;
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);

        // Single write from the load unit, then idle.
        cv = 3'b010;
        ca[SRC_LOAD] = 6'h05;
        cd[SRC_LOAD] = 72'hAB;
        run_cycle(1'b1, 1'b0);
        check("t2_wr_addr", 128'(wr_addr), 128'(6'h05));
        check("t2_wr_data", 128'(wr_data), 128'(72'hAB));
        check("t2_wr_src",  128'(wr_src),  128'(SRC_LOAD));
        cv = 3'b000;
        run_cycle(1'b1, 1'b0);

        // All sources valid from pointer 0: back-to-back rotation.
        run_cycle(1'b0, 1'b0);
        set_fixed();
        cv = 3'b111;
        for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b0);
        cv = 3'b000;
        run_cycle(1'b1, 1'b0);

        // Accept src0, stall three cycles with src2 waiting, then release.
        run_cycle(1'b0, 1'b0);
        cv = 3'b001;
        run_cycle(1'b1, 1'b0);
        cv = 3'b100;
        for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        check("t4_wr_src", 128'(wr_src), 128'(SRC_MUL));
        cv = 3'b000;
        run_cycle(1'b1, 1'b0);

        // Two sources writing the same address: serialised, later one lands last.
        run_cycle(1'b0, 1'b0);
        cv = 3'b011;
        ca[0] = 6'h0A; cd[0] = 72'h1;
        ca[1] = 6'h0A; cd[1] = 72'h2;
        run_cycle(1'b1, 1'b0);
        cv = 3'b010;
        run_cycle(1'b1, 1'b0);
        check("t5_last_data", 128'(wr_data), 128'(72'h2));
        cv = 3'b000;
        run_cycle(1'b1, 1'b0);

        // Reset during HOLD abandons the write; pending src2 is granted afterwards.
        set_fixed();
        cv = 3'b001;
        run_cycle(1'b1, 1'b0);
        cv = 3'b100;
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b1);
        run_cycle(1'b1, 1'b0);
        check("t6_wr_src", 128'(wr_src), 128'(SRC_MUL));
        check("t6_wr_en",  128'(wr_en),  128'(1'b1));

        // Random traffic honouring the hold-while-waiting rule.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (cv[i] && last_grant != i) begin
                    if ($urandom_range(0, 7) == 0) cv[i] = 1'b0;
                end else begin
                    cv[i] = 1'($urandom_range(0, 1));
                    ca[i] = AW'($urandom_range(0, 63));
                    rnd   = {$urandom, $urandom, $urandom};
                    cd[i] = rnd[DW-1:0];
                end
            end
            run_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
